// File: rtl/riscv_shift_unit_pkg.sv
// Shared types for the iterative RV32I shifter: op encoding, FSM states and latency helper.
// The package is imported by the shift-step datapath and by the control/top module.
`ifndef SHU_LATENCY
`define SHU_LATENCY(n) ((n) + 1)
`endif

package riscv_shift_unit_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } shift_op_e;

  typedef enum logic [1:0] {
    SHU_IDLE  = 2'b00,
    SHU_SHIFT = 2'b01,
    SHU_DONE  = 2'b10
  } shu_state_e;

  // Cycles from the accepting edge to the done cycle, inclusive of the done cycle.
  function automatic int shu_latency(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/riscv_shift_unit_step.sv
// One-bit shift datapath: returns acc shifted by a single position for the given op.
// The unused encoding 2'b11 falls through to a left shift.
module riscv_shift_unit_step
  import riscv_shift_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] acc_next
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_next = {acc[WIDTH-2:0], 1'b0};
    case (op)
      SH_SRL:  acc_next = {1'b0, acc[WIDTH-1:1]};
      SH_SRA:  acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_next = {acc[WIDTH-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/riscv_shift_unit.sv
// Multi-cycle shifter for SLL/SRL/SRA: one bit per clock, done pulses for one cycle and
// the registered result holds until the next shift completes.
module riscv_shift_unit
  import riscv_shift_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  shu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]   result_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] shamt_m;
  logic [1:0]         op_q;
  logic               accept;
  logic               last_step;

  // Upper shamt bits are architecturally ignored; shifts are modulo WIDTH.
  logic unused_shamt;
  assign unused_shamt = ^shamt[WIDTH-1:SHAMT_W];

  assign shamt_m   = shamt[SHAMT_W-1:0];
  assign accept    = start && (state_q == SHU_IDLE || state_q == SHU_DONE);
  assign last_step = (state_q == SHU_SHIFT) && (cnt_q == SHAMT_W'(1));

  riscv_shift_unit_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op       (op_q),
    .acc      (acc_q),
    .acc_next (acc_step)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHU_IDLE, SHU_DONE: begin
        if (start) begin
          state_d = (shamt_m == '0) ? SHU_DONE : SHU_SHIFT;
        end else begin
          state_d = SHU_IDLE;
        end
      end
      SHU_SHIFT: begin
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = SHU_DONE;
        end
      end
      default: state_d = SHU_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHU_SHIFT);
    done = (state_q == SHU_DONE);
  end

  assign result = result_q;

  // Operands are captured only on acceptance, so input changes during SHIFT have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= SH_SLL;
      result_q <= '0;
    end else if (accept) begin
      acc_q <= a;
      cnt_q <= shamt_m;
      op_q  <= op;
      if (shamt_m == '0) begin
        result_q <= a;
      end
    end else if (state_q == SHU_SHIFT) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - SHAMT_W'(1);
      if (last_step) begin
        result_q <= acc_step;
      end
    end
  end

endmodule

// File: tb/tb_riscv_shift_unit.sv
// Directed bench for riscv_shift_unit: latency, op semantics, masking, ignored start,
// back-to-back issue and mid-operation reset, all against hand-computed values.
module tb_riscv_shift_unit;
  import riscv_shift_unit_pkg::*;

  localparam int WIDTH = 32;
  localparam int MAX_WAIT = 40;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int n_checks;
  int n_pass;

  riscv_shift_unit #(
    .WIDTH(WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for exactly one edge (E0); returns #1 after E0 with start released.
  task automatic issue(input logic [1:0] op_v, input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] sh_v);
    op    = op_v;
    a     = a_v;
    shamt = sh_v;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for done, counting edges after E0; busy must be high in every cycle before it.
  task automatic wait_done(input string tag, input int edges_so_far, input int exp_n,
                           input logic [WIDTH-1:0] exp_res);
    int n;
    n = edges_so_far;
    while (!done && n < MAX_WAIT) begin
      if (!busy) check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_n);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
    check({tag, "_result"}, result, exp_res);
  endtask

  // One cycle after done with no new start: back to idle, pulse gone, result held.
  task automatic check_idle_after(input string tag, input logic [WIDTH-1:0] exp_res);
    tick();
    check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    bit saw_done;
    n_checks = 0;
    n_pass   = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = SH_SLL;
    a     = '0;
    shamt = '0;
    tick();
    tick();
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'h0);
    rst = 1'b0;
    tick();

    // SLL 0xf << 4: busy E1..E4, done after E4.
    issue(SH_SLL, 32'h0000000f, 32'd4);
    check("sll4_busy_e0", {31'b0, busy}, 32'd1);
    wait_done("sll4", 0, 4, 32'h000000f0);
    check_idle_after("sll4", 32'h000000f0);

    issue(SH_SRL, 32'h000000f0, 32'd4);
    wait_done("srl4", 0, 4, 32'h0000000f);
    check_idle_after("srl4", 32'h0000000f);

    issue(SH_SRA, 32'h80000000, 32'd31);
    wait_done("sra31", 0, 31, 32'hffffffff);
    check_idle_after("sra31", 32'hffffffff);

    issue(SH_SRL, 32'h80000000, 32'd31);
    wait_done("srl31", 0, 31, 32'h00000001);
    check_idle_after("srl31", 32'h00000001);

    // Bit 5 of shamt is masked off: 0x24 shifts by 4.
    issue(SH_SLL, 32'h00000001, 32'h00000024);
    wait_done("mask", 0, 4, 32'h00000010);
    check_idle_after("mask", 32'h00000010);

    // shamt=0: done right after E0, busy never high.
    issue(SH_SLL, 32'hdeadbeef, 32'd0);
    check("zero_busy", {31'b0, busy}, 32'd0);
    wait_done("zero", 0, 0, 32'hdeadbeef);
    check_idle_after("zero", 32'hdeadbeef);

    // Encoding 2'b11 behaves as SLL.
    issue(2'b11, 32'h00000001, 32'd3);
    wait_done("op11", 0, 3, 32'h00000008);
    check_idle_after("op11", 32'h00000008);

    // Start pulse at E3 during SHIFT is ignored.
    issue(SH_SLL, 32'h00000001, 32'd8);
    tick();
    tick();
    op    = SH_SRA;
    a     = 32'h0;
    shamt = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 32'hffffffff;
    check("ign_busy_e3", {31'b0, busy}, 32'd1);
    wait_done("ign", 3, 8, 32'h00000100);

    // Back-to-back: start accepted in the DONE cycle, no idle bubble.
    issue(SH_SRL, 32'h00000100, 32'd8);
    check("b2b_busy_next", {31'b0, busy}, 32'd1);
    check("b2b_result_held", result, 32'h00000100);
    wait_done("b2b", 0, 8, 32'h00000001);
    check_idle_after("b2b", 32'h00000001);

    // Reset at E5 of a 20-bit shift discards it completely.
    issue(SH_SLL, 32'h00000001, 32'd20);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_result", result, 32'h0);
    saw_done = 1'b0;
    repeat (25) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("rst_no_done", {31'b0, saw_done}, 32'd0);

    issue(SH_SLL, 32'h00000003, 32'd1);
    wait_done("post_rst", 0, 1, 32'h00000006);
    check_idle_after("post_rst", 32'h00000006);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
